// File: rtl/detector_jogada_pkg.sv
// detector_jogada_pkg
//   Shared definitions for the play detector: the FSM state type with its
//   fixed debug codes, and a one-hot check for the captured key sample.
//   No ports (package).
package detector_jogada_pkg;

  // State codes are visible on db_estado, so they are pinned explicitly.
  typedef enum logic [3:0] {
    OCIOSO         = 4'd0,
    FILTRANDO      = 4'd1,
    PULSO          = 4'd2,
    AGUARDA_SOLTAR = 4'd3
  } estado_t;

  // True when exactly one key is pressed (zero is not one-hot).
  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/detector_jogada_contador_filtro.sv
// contador_filtro
//   Saturating stability counter shared by the press filter and the release
//   filter. Counts up while enabled and holds at DEBOUNCE_CICLOS-1.
// Ports:
//   clock    in  system clock
//   reset    in  synchronous active-high reset
//   clear    in  restart the count at zero (wins over enable)
//   enable   in  advance the count by one
//   terminal out count has reached DEBOUNCE_CICLOS-1
module contador_filtro #(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = $clog2(DEBOUNCE_CICLOS);
  localparam logic [W-1:0] LIMITE = W'(DEBOUNCE_CICLOS - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority; stop at the limit so it never wraps.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMITE)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == LIMITE);

endmodule

// File: rtl/detector_jogada.sv
// detector_jogada
//   Debounces four push buttons and reports one accepted play per physical
//   press. A press must be stable for DEBOUNCE_CICLOS cycles to count, and
//   the keys must then be released for DEBOUNCE_CICLOS cycles before a new
//   press is looked at. Multi-key presses are never accepted.
//   Optional feature macro: JOGADA_INVALIDA_EN adds the jogada_invalida
//   output, a one-cycle pulse when a stable multi-key press is discarded.
// Ports:
//   clock           in   system clock
//   reset           in   synchronous active-high reset
//   chaves[3:0]     in   raw key levels (1 = pressed), asynchronous
//   habilita        in   controller allows a new play
//   jogada_feita    out  one-cycle pulse per accepted play
//   jogada[3:0]     out  one-hot code of the last accepted play
//   db_tem_jogada   out  OR of the synchronized keys
//   db_estado[3:0]  out  current FSM state code
//   jogada_invalida out  (JOGADA_INVALIDA_EN only) discarded multi-key press
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] chaves,
  input  logic       habilita,
  output logic       jogada_feita,
  output logic [3:0] jogada,
  output logic       db_tem_jogada,
  output logic [3:0] db_estado
`ifdef JOGADA_INVALIDA_EN
  ,
  output logic       jogada_invalida
`endif
);

  logic [3:0] sync1_q, sync1_d;
  logic [3:0] chaves_s_q, chaves_s_d;
  estado_t    state_q, state_d;
  logic [3:0] amostra_q, amostra_d;
  logic [3:0] jogada_q, jogada_d;
  logic       cnt_clear;
  logic       cnt_enable;
  logic       cnt_fim;

  contador_filtro #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_contador (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .terminal(cnt_fim)
  );

  // Two-stage synchronizer for the asynchronous key levels.
  always_comb begin
    sync1_d    = chaves;
    chaves_s_d = sync1_q;
  end

  // All state registers, including the synchronizer.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= 4'd0;
      chaves_s_q <= 4'd0;
      state_q    <= OCIOSO;
      amostra_q  <= 4'd0;
      jogada_q   <= 4'd0;
    end else begin
      sync1_q    <= sync1_d;
      chaves_s_q <= chaves_s_d;
      state_q    <= state_d;
      amostra_q  <= amostra_d;
      jogada_q   <= jogada_d;
    end
  end

  // Next state. The counter is held at zero unless a state explicitly
  // advances it, so every entry into FILTRANDO or AGUARDA_SOLTAR starts a
  // fresh count. In FILTRANDO the counter sits at its limit on the
  // DEBOUNCE_CICLOS-th matching cycle, which is when the decision is made.
  always_comb begin
    state_d    = state_q;
    amostra_d  = amostra_q;
    jogada_d   = jogada_q;
    cnt_clear  = 1'b1;
    cnt_enable = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (habilita && (chaves_s_q != 4'd0)) begin
          amostra_d = chaves_s_q;
          state_d   = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (!habilita || (chaves_s_q == 4'd0)) begin
          state_d = OCIOSO;
        end else if (chaves_s_q != amostra_q) begin
          amostra_d = chaves_s_q;
        end else if (cnt_fim) begin
          if (is_one_hot(amostra_q)) begin
            jogada_d = amostra_q;
            state_d  = PULSO;
          end else begin
            state_d = AGUARDA_SOLTAR;
          end
        end else begin
          cnt_clear  = 1'b0;
          cnt_enable = 1'b1;
        end
      end
      PULSO: begin
        state_d = AGUARDA_SOLTAR;
      end
      AGUARDA_SOLTAR: begin
        if (chaves_s_q == 4'd0) begin
          if (cnt_fim) begin
            state_d = OCIOSO;
          end else begin
            cnt_clear  = 1'b0;
            cnt_enable = 1'b1;
          end
        end
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  // Outputs. The pulse is masked by reset so a reset landing on PULSO
  // never lets a play through.
  always_comb begin
    jogada_feita  = (state_q == PULSO) && !reset;
    jogada        = jogada_q;
    db_tem_jogada = |chaves_s_q;
    db_estado     = state_q;
  end

`ifdef JOGADA_INVALIDA_EN
  logic invalida_q, invalida_d;

  // The only FILTRANDO -> AGUARDA_SOLTAR path is a stable multi-key press.
  always_comb begin
    invalida_d = (state_q == FILTRANDO) && (state_d == AGUARDA_SOLTAR);
  end

  // Registered so the pulse lines up with the first AGUARDA_SOLTAR cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      invalida_q <= 1'b0;
    end else begin
      invalida_q <= invalida_d;
    end
  end

  assign jogada_invalida = invalida_q;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada
//   Self-checking bench for detector_jogada with DEBOUNCE_CICLOS=4. A
//   behavioural model tracks the play rules in terms of "matching cycles
//   seen" and "release cycles seen"; each scenario task compares the DUT
//   outputs with it every cycle and adds scenario-level timing checks.
module tb_detector_jogada;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       habilita = 1'b0;
  logic [3:0] chaves = 4'd0;
  logic       jogada_feita;
  logic [3:0] jogada;
  logic       db_tem_jogada;
  logic [3:0] db_estado;
  logic       inv_obs;

`ifdef JOGADA_INVALIDA_EN
  logic jogada_invalida;
  assign inv_obs = jogada_invalida;
`else
  assign inv_obs = 1'b0;
`endif

  detector_jogada #(.DEBOUNCE_CICLOS(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .chaves       (chaves),
    .habilita     (habilita),
    .jogada_feita (jogada_feita),
    .jogada       (jogada),
    .db_tem_jogada(db_tem_jogada),
    .db_estado    (db_estado)
`ifdef JOGADA_INVALIDA_EN
    ,
    .jogada_invalida(jogada_invalida)
`endif
  );

  always #5 clock = ~clock;

  // Observed outputs {invalida, feita, jogada, estado, tem_jogada}.
  logic [10:0] obs_vec;
  assign obs_vec = {inv_obs, jogada_feita, jogada, db_estado, db_tem_jogada};

  // Model: m_s1/m_s2 are the key samples one and two edges old.
  int         m_mode = 0;
  int         m_hits = 0;
  int         m_zeros = 0;
  logic [3:0] m_amo = 4'd0;
  logic [3:0] m_jog = 4'd0;
  logic [3:0] m_s1 = 4'd0;
  logic [3:0] m_s2 = 4'd0;
  logic       m_inv = 1'b0;
  logic [10:0] exp_vec = 11'd0;
  int         n_tick = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  // Drive one cycle of inputs, advance the model over the clock edge.
  task automatic tick(input logic [3:0] ch, input logic hab, input logic rst);
    logic [3:0] s;
    @(negedge clock);
    chaves = ch;
    habilita = hab;
    reset = rst;
    @(posedge clock);
    n_tick++;
    m_inv = 1'b0;
    if (rst) begin
      m_mode = 0; m_hits = 0; m_zeros = 0;
      m_amo = 4'd0; m_jog = 4'd0; m_s1 = 4'd0; m_s2 = 4'd0;
    end else begin
      s = m_s2;
      case (m_mode)
        0: if (hab && s != 4'd0) begin m_amo = s; m_hits = 0; m_mode = 1; end
        1: begin
          if (!hab || s == 4'd0) m_mode = 0;
          else if (s != m_amo) begin m_amo = s; m_hits = 0; end
          else begin
            m_hits++;
            if (m_hits == D) begin
              m_zeros = 0;
              if ($countones(m_amo) == 1) begin m_jog = m_amo; m_mode = 2; end
              else begin m_mode = 3; m_inv = 1'b1; end
            end
          end
        end
        2: begin m_mode = 3; m_zeros = 0; end
        default: begin
          if (s != 4'd0) m_zeros = 0;
          else begin m_zeros++; if (m_zeros == D) m_mode = 0; end
        end
      endcase
      m_s2 = m_s1;
      m_s1 = ch;
    end
`ifdef JOGADA_INVALIDA_EN
    exp_vec[10] = m_inv;
`else
    exp_vec[10] = 1'b0;
`endif
    exp_vec[9:0] = {(m_mode == 2), m_jog, 4'(m_mode), |m_s2};
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(4'($urandom_range(0, 15)), 1'b1, 1'b1);
      n_checks++;
      if (obs_vec !== 11'd0) begin
        n_errors++;
        $display("[TB] FAIL reset tick %0d: outputs %b expected %b", n_tick, obs_vec, 11'd0);
      end
    end
  endtask

  task automatic test_single_press();
    logic [3:0] key, last;
    logic [19:0] seq;
    int press_tick, pulse_tick, pulses;
    key = 4'(1 << $urandom_range(0, 3));
    seq = '1; last = 4'hF; pulses = 0; pulse_tick = -100; press_tick = 0;
    for (int i = 0; i < 18; i++) begin
      tick((i < 10) ? key : 4'd0, 1'b1, 1'b0);
      if (i == 0) press_tick = n_tick;
      if (jogada_feita === 1'b1) begin pulses++; pulse_tick = n_tick; end
      if (db_estado !== last) begin seq = {seq[15:0], db_estado}; last = db_estado; end
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("[TB] FAIL single_press tick %0d: outputs %b expected %b", n_tick, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (pulses != 1) begin n_errors++; $display("[TB] FAIL single_press pulses: got %0d expected 1", pulses); end
    // Key changes in the cycle before press_tick; pulse cycle counted from there.
    n_checks++;
    if (pulse_tick - press_tick + 1 != 2 + 1 + D) begin
      n_errors++;
      $display("[TB] FAIL single_press latency: got %0d expected %0d", pulse_tick - press_tick + 1, 2 + 1 + D);
    end
    n_checks++;
    if (jogada !== key) begin n_errors++; $display("[TB] FAIL single_press jogada: got %b expected %b", jogada, key); end
    n_checks++;
    if (seq !== 20'h01230) begin n_errors++; $display("[TB] FAIL single_press states: got %h expected 01230", seq); end
  endtask

  task automatic test_bounce();
    logic [3:0] key;
    int pulses_toggle, pulses_after;
    key = {m_jog[2:0], m_jog[3]};
    pulses_toggle = 0; pulses_after = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < 12) tick((((i / 2) % 2) == 0) ? key : 4'd0, 1'b1, 1'b0);
      else tick((i < 24) ? key : 4'd0, 1'b1, 1'b0);
      if (jogada_feita === 1'b1) begin
        if (i < 14) pulses_toggle++; else pulses_after++;
      end
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("[TB] FAIL bounce tick %0d: outputs %b expected %b", n_tick, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (pulses_toggle != 0) begin n_errors++; $display("[TB] FAIL bounce toggling pulses: got %0d expected 0", pulses_toggle); end
    n_checks++;
    if (pulses_after != 1) begin n_errors++; $display("[TB] FAIL bounce stable pulses: got %0d expected 1", pulses_after); end
    n_checks++;
    if (jogada !== key) begin n_errors++; $display("[TB] FAIL bounce jogada: got %b expected %b", jogada, key); end
  endtask

  task automatic test_multi();
    logic [3:0] v, prev;
    int pulses, invs, saw_wait;
    v = 4'b0011;
    if ($urandom_range(0, 1) == 1) begin
      do v = 4'($urandom_range(1, 15)); while ($countones(v) < 2);
    end
    prev = m_jog; pulses = 0; invs = 0; saw_wait = 0;
    for (int i = 0; i < 18; i++) begin
      tick((i < 10) ? v : 4'd0, 1'b1, 1'b0);
      if (jogada_feita === 1'b1) pulses++;
      if (inv_obs === 1'b1) invs++;
      if (db_estado === 4'd3) saw_wait++;
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("[TB] FAIL multi tick %0d: outputs %b expected %b", n_tick, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (pulses != 0) begin n_errors++; $display("[TB] FAIL multi pulses: got %0d expected 0", pulses); end
    n_checks++;
    if (jogada !== prev) begin n_errors++; $display("[TB] FAIL multi jogada: got %b expected %b", jogada, prev); end
    n_checks++;
    if (saw_wait == 0) begin n_errors++; $display("[TB] FAIL multi wait_state: got 0 cycles expected >0"); end
`ifdef JOGADA_INVALIDA_EN
    n_checks++;
    if (invs != 1) begin n_errors++; $display("[TB] FAIL multi invalida: got %0d expected 1", invs); end
`endif
  endtask

  task automatic test_habilita();
    int pulses, pulse_tick, raise_tick;
    pulses = 0; pulse_tick = -100; raise_tick = 0;
    for (int i = 0; i < 8; i++) begin
      tick(4'b1000, 1'b0, 1'b0);
      if (jogada_feita === 1'b1) pulses++;
      n_checks++;
      if (db_estado !== 4'd0 || obs_vec !== exp_vec) begin
        n_errors++;
        $display("[TB] FAIL habilita_low tick %0d: outputs %b expected %b", n_tick, obs_vec, exp_vec);
      end
    end
    for (int i = 0; i < 16; i++) begin
      tick((i < 8) ? 4'b1000 : 4'd0, 1'b1, 1'b0);
      if (i == 0) raise_tick = n_tick;
      if (jogada_feita === 1'b1) begin pulses++; pulse_tick = n_tick; end
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("[TB] FAIL habilita_high tick %0d: outputs %b expected %b", n_tick, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (pulses != 1) begin n_errors++; $display("[TB] FAIL habilita pulses: got %0d expected 1", pulses); end
    // Key already synchronized: capture on the raise edge, then D matches.
    n_checks++;
    if (pulse_tick - raise_tick != D) begin
      n_errors++;
      $display("[TB] FAIL habilita latency: got %0d expected %0d", pulse_tick - raise_tick, D);
    end
  endtask

  task automatic test_release();
    logic found;
    int pulses, release_tick, ret_tick;
    found = 1'b0; pulses = 0; release_tick = 0; ret_tick = -100;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(4'b0010, 1'b1, 1'b0);
      if (jogada_feita === 1'b1) begin found = 1'b1; pulses++; end
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("[TB] FAIL release_press tick %0d: outputs %b expected %b", n_tick, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (!found) begin n_errors++; $display("[TB] FAIL release_press timeout: got no pulse expected 1"); end
    for (int i = 0; i < 38; i++) begin
      if (i < 20) tick(4'b0010, 1'b1, 1'b0);
      else if (i < 28) tick(((i - 20) % 4 >= 2) ? 4'b0010 : 4'd0, 1'b1, 1'b0);
      else tick(4'd0, 1'b1, 1'b0);
      if (i == 28) release_tick = n_tick;
      if (i >= 28 && ret_tick < 0 && db_estado === 4'd0) ret_tick = n_tick;
      if (jogada_feita === 1'b1) pulses++;
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("[TB] FAIL release tick %0d: outputs %b expected %b", n_tick, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (pulses != 1) begin n_errors++; $display("[TB] FAIL release pulses: got %0d expected 1", pulses); end
    // Final release reaches the FSM two edges later; D zero cycles after that.
    n_checks++;
    if (ret_tick - release_tick != D + 1) begin
      n_errors++;
      $display("[TB] FAIL release return: got %0d expected %0d", ret_tick - release_tick, D + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] key;
    int filt, pulses;
    key = 4'(1 << $urandom_range(0, 3));
    filt = 0; pulses = 0;
    for (int i = 0; i < 12 && filt < 3; i++) begin
      tick(key, 1'b1, 1'b0);
      if (db_estado === 4'd1) filt++;
    end
    n_checks++;
    if (filt != 3) begin n_errors++; $display("[TB] FAIL reset_mid filter: got %0d cycles expected 3", filt); end
    tick(4'd0, 1'b1, 1'b1);
    n_checks++;
    if (obs_vec !== 11'd0) begin
      n_errors++;
      $display("[TB] FAIL reset_mid outputs: got %b expected %b", obs_vec, 11'd0);
    end
    for (int i = 0; i < 10; i++) begin
      tick(4'd0, 1'b1, 1'b0);
      if (jogada_feita === 1'b1) pulses++;
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("[TB] FAIL reset_mid tick %0d: outputs %b expected %b", n_tick, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (pulses != 0) begin n_errors++; $display("[TB] FAIL reset_mid pulses: got %0d expected 0", pulses); end
  endtask

  task automatic test_random();
    logic [3:0] ch;
    logic hab;
    int left, r;
    ch = 4'd0; hab = 1'b1; left = 0;
    for (int i = 0; i < 400; i++) begin
      if (left == 0) begin
        r = $urandom_range(0, 9);
        if (r < 5) ch = 4'd0;
        else if (r < 8) ch = 4'(1 << $urandom_range(0, 3));
        else ch = 4'($urandom_range(0, 15));
        hab = ($urandom_range(0, 99) < 85);
        left = $urandom_range(1, 8);
      end
      left--;
      tick(ch, hab, ($urandom_range(0, 99) == 0));
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("[TB] FAIL random tick %0d: outputs %b expected %b", n_tick, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_habilita();
    test_release();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
DETECTOR_JOGADA -- requirements
Module: detector_jogada

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 50000, is the number of consecutive stable clock cycles required to accept a press or a release; legal range >= 2.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 chaves  input  4  raw push-button levels, 1 = pressed, asynchronous to clock.
REQ-005 habilita  input  1  controller permission to accept a new play.
REQ-006 jogada_feita  output  1  single-cycle pulse marking one accepted play.
REQ-007 jogada  output  4  registered one-hot code of the last accepted play.
REQ-008 db_tem_jogada  output  1  debug: OR of the synchronized chaves.
REQ-009 db_estado  output  4  debug: current FSM state code.

Function
REQ-010 chaves SHALL pass through a two-flop synchronizer; all logic below uses the synchronized value chaves_s.
REQ-011 FSM states and codes SHALL be OCIOSO=0, FILTRANDO=1, PULSO=2, AGUARDA_SOLTAR=3; other codes are unreachable and SHALL return to OCIOSO on the next cycle.
REQ-012 OCIOSO: if habilita=1 and chaves_s!=0, capture amostra<=chaves_s, clear the counter, and go to FILTRANDO; otherwise stay.
REQ-013 FILTRANDO with habilita=0: return to OCIOSO with no pulse.
REQ-014 FILTRANDO with chaves_s=0: return to OCIOSO with no pulse.
REQ-015 FILTRANDO with a nonzero chaves_s different from amostra: set amostra<=chaves_s and clear the counter.
REQ-016 FILTRANDO with chaves_s=amostra: increment the counter.
REQ-017 When the counter reaches DEBOUNCE_CICLOS-1 in FILTRANDO and amostra is one-hot: set jogada<=amostra and go to PULSO.
REQ-018 When the counter reaches DEBOUNCE_CICLOS-1 in FILTRANDO and amostra is not one-hot: go to AGUARDA_SOLTAR with jogada unchanged.
REQ-019 PULSO SHALL assert jogada_feita for exactly one cycle, then go unconditionally to AGUARDA_SOLTAR.
REQ-020 AGUARDA_SOLTAR SHALL count consecutive cycles with chaves_s=0 and return to OCIOSO after DEBOUNCE_CICLOS of them; any nonzero chaves_s clears the count. habilita is ignored in this state.
REQ-021 One physical press SHALL produce at most one jogada_feita.
REQ-022 Latency from a stable one-hot chaves edge to jogada_feita SHALL be 2 (synchronizer) + 1 (OCIOSO capture) + DEBOUNCE_CICLOS cycles.
REQ-023 jogada SHALL hold its value until the next accepted play or reset, and is valid in the cycle jogada_feita is high.
REQ-024 Counter width SHALL be $clog2(DEBOUNCE_CICLOS); the counter SHALL saturate and never wrap.

Reset
REQ-025 reset=1 SHALL force the state to OCIOSO and clear jogada=0, jogada_feita=0, amostra=0, the counter, the synchronizer flops and jogada_invalida; db_estado then reads 0.
REQ-026 Reset asserted mid-filter or during PULSO SHALL suppress any pending pulse.

Configuration
REQ-027 With JOGADA_INVALIDA_EN defined, an extra output jogada_invalida (1 bit) SHALL pulse for one cycle on the REQ-018 transition.
REQ-028 Without JOGADA_INVALIDA_EN, jogada_invalida SHALL be absent and multi-key presses SHALL be discarded silently.

Structure
REQ-029 Package detector_jogada_pkg SHALL hold the state type/codes and a one-hot check function.
REQ-030 The press/release counter SHALL be one sub-module, contador_filtro, with clear, enable, terminal-count output and a DEBOUNCE_CICLOS parameter.

Verification (DEBOUNCE_CICLOS=4)
REQ-031 habilita=1; chaves=0100 held for 10 cycles -> exactly one jogada_feita pulse 7 cycles after the edge; jogada=0100; db_estado sequence 0,1,2,3.
REQ-032 chaves=0001 toggling every 2 cycles for 12 cycles, then held -> no pulse during the toggling; one pulse after a stable window; jogada=0001.
REQ-033 chaves=0011 held 10 cycles -> no jogada_feita; jogada unchanged; with JOGADA_INVALIDA_EN, one jogada_invalida pulse.
REQ-034 habilita=0 with chaves=1000 held -> no pulse and state stays 0; raising habilita while the key is still held -> a pulse after the filter window.
REQ-035 Press 0010 until the pulse, keep it held 20 cycles, release with 2-cycle bounces -> exactly one pulse; return to OCIOSO only 4 cycles after the last bounce.
REQ-036 reset pulsed at cycle 3 of FILTRANDO -> no pulse; all outputs 0 the next cycle.
